// File: rtl/gpio_in_debounce_pkg.sv
// gpio_in_debounce: shared defaults and helpers.
// Default widths match the wb_gpio_single slave instance.
package gpio_in_debounce_pkg;

  localparam int GW_DEF   = 2;
  localparam int DBW_DEF  = 16;
  localparam int SYNC_DEF = 2;

  // Keep the synchroniser depth inside its usable 2..4 range.
  function automatic int sync_depth(input int d);
    if (d < 2) return 2;
    if (d > 4) return 4;
    return d;
  endfunction

endpackage

// File: rtl/gpio_in_debounce_if.sv
// gpio_in_debounce: pad/slave/CPU-side signal bundle.
// slave = the conditioning block, master = its environment.
interface gpio_in_debounce_if
  import gpio_in_debounce_pkg::*;
#(
  parameter int GW  = GW_DEF,
  parameter int DBW = DBW_DEF
);

  logic [GW-1:0]  pad_i;
  logic [DBW-1:0] db_limit;
  logic [GW-1:0]  gpio_i;
  logic [GW-1:0]  rise_o;
  logic [GW-1:0]  fall_o;
  logic [GW-1:0]  edge_sts;
  logic [GW-1:0]  sts_clr;
  logic [GW-1:0]  irq_en;
  logic           irq;

  modport slave (
    input  pad_i, db_limit, sts_clr, irq_en,
    output gpio_i, rise_o, fall_o, edge_sts, irq
  );

  modport master (
    output pad_i, db_limit, sts_clr, irq_en,
    input  gpio_i, rise_o, fall_o, edge_sts, irq
  );

endinterface

// File: rtl/gpio_db_bit.sv
// gpio_db_bit: synchroniser, debounce counter, clean level,
// edge pulses and sticky edge flag for one GPIO bit.
module gpio_db_bit #(
  parameter int DBW  = 16,
  parameter int SYNC = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           pad,
  input  logic [DBW-1:0] db_limit,
  input  logic           sts_clr,
  output logic           lvl,
  output logic           rise,
  output logic           fall,
  output logic           sts
);

  logic [SYNC-1:0] sync_q;
  logic [DBW-1:0]  cnt;
  logic            s;
  logic            qual;

  assign s    = sync_q[SYNC-1];
  assign qual = (s != lvl) && (cnt >= db_limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC-2:0], pad};
    end
  end

  // cnt only increments while below db_limit, so it cannot wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      lvl  <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (s == lvl) begin
        cnt <= '0;
      end else if (qual) begin
        lvl  <= s;
        cnt  <= '0;
        rise <= s;
        fall <= ~s;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // A new edge outranks a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sts <= 1'b0;
    end else if (qual) begin
      sts <= 1'b1;
    end else if (sts_clr) begin
      sts <= 1'b0;
    end
  end

endmodule

// File: rtl/gpio_in_debounce.sv
// gpio_in_debounce: per-bit pad conditioning for the GPIO slave
// plus the maskable edge interrupt.
module gpio_in_debounce
  import gpio_in_debounce_pkg::*;
#(
  parameter int GW   = GW_DEF,
  parameter int DBW  = DBW_DEF,
  parameter int SYNC = SYNC_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  gpio_in_debounce_if.slave  bus
);

  localparam int SD = sync_depth(SYNC);

  logic [GW-1:0] lvl;
  logic [GW-1:0] rise;
  logic [GW-1:0] fall;
  logic [GW-1:0] sts;

  for (genvar i = 0; i < GW; i++) begin : g_bit
    gpio_db_bit #(
      .DBW  (DBW),
      .SYNC (SD)
    ) u_bit (
      .clk      (clk),
      .rst_n    (rst_n),
      .pad      (bus.pad_i[i]),
      .db_limit (bus.db_limit),
      .sts_clr  (bus.sts_clr[i]),
      .lvl      (lvl[i]),
      .rise     (rise[i]),
      .fall     (fall[i]),
      .sts      (sts[i])
    );
  end

  assign bus.gpio_i   = lvl;
  assign bus.rise_o   = rise;
  assign bus.fall_o   = fall;
  assign bus.edge_sts = sts;
  assign bus.irq      = |(sts & bus.irq_en);

endmodule
